// File: rtl/vpe_responder.sv
// vpe_responder: vector processing element that answers one SFU request at a
// time. A request is captured on acceptance, then processed LANES elements per
// cycle; when the last chunk finishes, res_valid pulses for one cycle together
// with the final saturated sum in res_sca.
//
// Elements are signed Q8.8. Each product is the full-width signed product,
// arithmetic-shifted right by 8 and saturated. In mode 0 sca2 is then added
// with a second saturation.
//
// Ports
//   clk, rst_n           clock (rising edge), async active-low reset
//   req_valid/req_ready  request handshake; ready only while idle
//   vec1, vec2           operand vectors, DIM_SIZE x DATA_WIDTH
//   sca1, sca2           scalar multiplier / scalar addend (mode 0)
//   mode                 0: vec1*sca1+sca2, 1: vec1*vec2 elementwise
//   res_vec              result vector, rewritten chunk by chunk while busy
//   res_sca              saturated sum of all res_vec elements
//   res_valid            one-cycle pulse when the result is complete

// Single lane: one multiply with Q8.8 rescale and saturation, optional
// saturating addend.
module vpe_lane #(
  parameter int DW   = 16,
  parameter int FRAC = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] sca1,
  input  logic [DW-1:0] sca2,
  input  logic          mode,
  output logic [DW-1:0] res
);
  localparam logic [DW-1:0] S_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] S_MIN = {1'b1, {(DW-1){1'b0}}};

  logic signed [DW-1:0]   op_a, op_m;
  logic signed [2*DW-1:0] prod, shr;
  logic [DW-1:0]          psat, asat;
  logic [DW:0]            add;

  always_comb begin
    op_a = a;
    op_m = mode ? b : sca1;
    prod = op_a * op_m;
    // >>> on a signed value floors, i.e. truncates toward minus infinity
    shr  = prod >>> FRAC;
    // In range only when all bits above the result sign agree with it
    if ((&shr[2*DW-1:DW-1]) || !(|shr[2*DW-1:DW-1]))
      psat = shr[DW-1:0];
    else
      psat = shr[2*DW-1] ? S_MIN : S_MAX;
    add = {psat[DW-1], psat} + {sca2[DW-1], sca2};
    if (add[DW] != add[DW-1])
      asat = add[DW] ? S_MIN : S_MAX;
    else
      asat = add[DW-1:0];
    res = mode ? psat : asat;
  end
endmodule

module vpe_responder #(
  parameter int DIM_SIZE   = 128,
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic [DIM_SIZE-1:0][DATA_WIDTH-1:0]  vec1,
  input  logic [DIM_SIZE-1:0][DATA_WIDTH-1:0]  vec2,
  input  logic [DATA_WIDTH-1:0]                sca1,
  input  logic [DATA_WIDTH-1:0]                sca2,
  input  logic                                 mode,
  output logic [DIM_SIZE-1:0][DATA_WIDTH-1:0]  res_vec,
  output logic [DATA_WIDTH-1:0]                res_sca,
  output logic                                 res_valid
);
  localparam int CHUNKS = DIM_SIZE / LANES;
  localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int IDX_W  = (DIM_SIZE > 1) ? $clog2(DIM_SIZE) : 1;
  // Sum of DIM_SIZE DATA_WIDTH-bit values cannot overflow this width
  localparam int ACC_W  = DATA_WIDTH + $clog2(DIM_SIZE);
  localparam int DW     = DATA_WIDTH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [DW-1:0] S_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] S_MIN = {1'b1, {(DW-1){1'b0}}};

  generate
    if (DIM_SIZE % LANES != 0) begin : g_bad_cfg
      $error("vpe_responder: DIM_SIZE must be divisible by LANES");
    end
  endgenerate

  logic [1:0]                          state_q, state_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic signed [ACC_W-1:0]             acc_q, acc_d;
  logic [DIM_SIZE-1:0][DW-1:0]         vec1_q, vec1_d;
  logic [DIM_SIZE-1:0][DW-1:0]         vec2_q, vec2_d;
  logic [DW-1:0]                       sca1_q, sca1_d;
  logic [DW-1:0]                       sca2_q, sca2_d;
  logic                                mode_q, mode_d;
  logic [DIM_SIZE-1:0][DW-1:0]         res_vec_q, res_vec_d;
  logic [DW-1:0]                       res_sca_q, res_sca_d;
  logic                                res_valid_q, res_valid_d;

  logic [IDX_W-1:0]                    base;
  logic [LANES-1:0][DW-1:0]            lane_a, lane_b, lane_res;
  logic signed [ACC_W-1:0]             chunk_sum, fin_sum;
  logic [DW-1:0]                       fin_sat;

  assign base = IDX_W'(cnt_q) * IDX_W'(LANES);

  // Lane array works on the chunk selected by cnt, always from captured operands
  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign lane_a[l] = vec1_q[base + IDX_W'(l)];
      assign lane_b[l] = vec2_q[base + IDX_W'(l)];
      vpe_lane #(.DW(DW), .FRAC(8)) u_lane (
        .a    (lane_a[l]),
        .b    (lane_b[l]),
        .sca1 (sca1_q),
        .sca2 (sca2_q),
        .mode (mode_q),
        .res  (lane_res[l])
      );
    end
  endgenerate

  always_comb begin
    chunk_sum = '0;
    for (int l = 0; l < LANES; l++)
      chunk_sum = chunk_sum + ACC_W'($signed(lane_res[l]));
    fin_sum = acc_q + chunk_sum;
    // Narrow to DW only at the end; accumulator itself never saturates
    if ((&fin_sum[ACC_W-1:DW-1]) || !(|fin_sum[ACC_W-1:DW-1]))
      fin_sat = fin_sum[DW-1:0];
    else
      fin_sat = fin_sum[ACC_W-1] ? S_MIN : S_MAX;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    vec1_d      = vec1_q;
    vec2_d      = vec2_q;
    sca1_d      = sca1_q;
    sca2_d      = sca2_q;
    mode_d      = mode_q;
    res_vec_d   = res_vec_q;
    res_sca_d   = res_sca_q;
    res_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          vec1_d  = vec1;
          vec2_d  = vec2;
          sca1_d  = sca1;
          sca2_d  = sca2;
          mode_d  = mode;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int l = 0; l < LANES; l++)
          res_vec_d[base + IDX_W'(l)] = lane_res[l];
        acc_d = fin_sum;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(CHUNKS - 1)) begin
          cnt_d       = '0;
          res_sca_d   = fin_sat;
          res_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      vec1_q      <= '0;
      vec2_q      <= '0;
      sca1_q      <= '0;
      sca2_q      <= '0;
      mode_q      <= 1'b0;
      res_vec_q   <= '0;
      res_sca_q   <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      vec1_q      <= vec1_d;
      vec2_q      <= vec2_d;
      sca1_q      <= sca1_d;
      sca2_q      <= sca2_d;
      mode_q      <= mode_d;
      res_vec_q   <= res_vec_d;
      res_sca_q   <= res_sca_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign res_vec   = res_vec_q;
  assign res_sca   = res_sca_q;
  assign res_valid = res_valid_q;
endmodule
